// File: rtl/lfsr_shift_reg.sv
// Multi-mode shift register with a Fibonacci LFSR mode.
// Each step applies one of hold, load, shift, rotate or LFSR update.
// A step is either a single enabled step while idle, or part of a counted
// run started with start/steps. During a run the operation is latched and
// d/sin are taken live. done pulses for one cycle when a run completes.
module lfsr_shift_reg #(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [WIDTH-1:0] TAPS        = 8'hB8,
   parameter int               CNT_W       = 8
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   input  logic             start,
   input  logic [CNT_W-1:0] steps,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   localparam logic [2:0] OP_HOLD = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_SHR  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;
   localparam logic [2:0] OP_ROR  = 3'b101;
   localparam logic [2:0] OP_LFSR = 3'b110;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [2:0]       mode_reg, mode_next;
   logic [WIDTH-1:0] q_reg, q_next;
   logic             done_reg, done_next;

   logic [2:0]       op_sel;
   logic [WIDTH-1:0] step_q;
   logic [WIDTH-1:0] tapped;
   logic             feedback;

   // Per-bit tap gating; the feedback bit is the parity of the tapped bits.
   // An all-zero register therefore stays zero in LFSR mode.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_tap
         assign tapped[gi] = q_reg[gi] & TAPS[gi];
      end
   endgenerate

   assign feedback = ^tapped;

   // Operation select: latched code during a run, live code while idle.
   always_comb begin
      op_sel = (state_reg == S_RUN) ? mode_reg : mode;
   end

   // One shared step datapath computing the register value after one step.
   always_comb begin
      step_q = q_reg;
      case (op_sel)
         OP_HOLD: step_q = q_reg;
         OP_LOAD: step_q = d;
         OP_SHL:  step_q = {q_reg[WIDTH-2:0], sin};
         OP_SHR:  step_q = {sin, q_reg[WIDTH-1:1]};
         OP_ROL:  step_q = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
         OP_ROR:  step_q = {q_reg[0], q_reg[WIDTH-1:1]};
         OP_LFSR: step_q = {q_reg[WIDTH-2:0], feedback};
         default: step_q = q_reg;
      endcase
   end

   // State register and datapath registers; clear acts immediately.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         mode_reg  <= OP_HOLD;
         q_reg     <= RESET_VALUE;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         mode_reg  <= mode_next;
         q_reg     <= q_next;
         done_reg  <= done_next;
      end
   end

   // Next-state logic. A start with zero steps completes at once without
   // entering the run state. In the run state the counter holds the number
   // of steps still to apply, so the last step is the one seen with count 1.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      mode_next  = mode_reg;
      q_next     = q_reg;
      done_next  = 1'b0;
      if (state_reg == S_RUN) begin
         q_next   = step_q;
         cnt_next = cnt_reg - CNT_ONE;
         if (cnt_reg == CNT_ONE) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
         end
      end else if (start) begin
         mode_next = mode;
         cnt_next  = steps;
         if (steps == CNT_ZERO) begin
            done_next = 1'b1;
         end else begin
            state_next = S_RUN;
         end
      end else if (en) begin
         q_next = step_q;
      end
   end

   // Outputs decoded from the registered state.
   always_comb begin
      q    = q_reg;
      sout = q_reg[WIDTH-1];
      busy = (state_reg == S_RUN);
      done = done_reg;
   end

endmodule

// File: doc/lfsr_shift_reg.md
LFSR_SHIFT_REG -- requirements
Module: lfsr_shift_reg

Interface
- REQ-001: The block SHALL take parameter WIDTH, default 8: register width in bits, legal range 2..64.
- REQ-002: The block SHALL take parameter RESET_VALUE, default all-zeros: per-bit clear value (1 bits act as set flops, 0 bits as clear flops).
- REQ-003: The block SHALL take parameter TAPS, default 8'hB8: LFSR feedback mask of WIDTH bits.
- REQ-004: The block SHALL take parameter CNT_W, default 8: width of the step counter.
- REQ-005: The block SHALL have one clock and an asynchronous, active-high reset. The ports are:
  clk  in  1  sole clock, rising edge.
  clear  in  1  asynchronous active-high reset.
  en  in  1  single-step enable while idle.
  mode  in  3  operation select.
  d  in  WIDTH  parallel load data.
  sin  in  1  serial input.
  start  in  1  begin multi-step run.
  steps  in  CNT_W  run length.
  q  out  WIDTH  register contents.
  sout  out  1  equals q[WIDTH-1], combinational.
  busy  out  1  run in progress.
  done  out  1  one-cycle run-complete pulse.

Function
- REQ-006: Each step SHALL apply one operation, selected by mode:
  000 hold.
  001 load d.
  010 shift left: sin enters bit 0.
  011 shift right: sin enters the MSB.
  100 rotate left.
  101 rotate right.
  110 Fibonacci LFSR: q <= {q[WIDTH-2:0], ^(q & TAPS)}.
  111 hold (reserved).
- REQ-007: When idle (busy=0) and start=0, at a rising edge with en=1 the block SHALL apply one step using the live mode, d and sin; with en=0 q SHALL hold.
- REQ-008: When idle and start=1 at a rising edge, the block SHALL latch mode and steps, leave q unchanged, and ignore en in that cycle.
- REQ-009: On a start with steps=N>0, the block SHALL set busy=1 at that edge (edge 0).
  - At edges 1..N it SHALL apply the latched mode once per edge, using live d and sin.
  - At edge N it SHALL clear busy and assert done for exactly one cycle.
- REQ-010: On a start with steps=0, q SHALL be unchanged, busy SHALL stay 0, and done SHALL pulse for one cycle after edge 0.
- REQ-011: While busy=1, en, mode, start and steps SHALL be ignored; a start in the same cycle as done=1 (idle) SHALL be accepted.
- REQ-012: steps SHALL be treated as unsigned, giving a maximum run of 2^CNT_W-1 steps; the counter SHALL NOT wrap within a run.
- REQ-013: The LFSR all-zero state SHALL have no special handling; it remains zero.
- REQ-014: done SHALL be 0 in every cycle other than the single completion cycle.

Reset
- REQ-015: While clear=1, asynchronously and independent of clk: q=RESET_VALUE, busy=0, done=0, counter=0, latched mode=000.
- REQ-016: Asserting clear mid-run SHALL abort the run with no done pulse.
- REQ-017: After clear deasserts, the block SHALL be idle; the first rising edge with clear=0 SHALL act per REQ-007/008.

Verification (WIDTH=8, RESET_VALUE=8'hA5, TAPS=8'hB8)
- REQ-018: Assert clear with no clock running -> q=8'hA5, busy=0, done=0 immediately.
- REQ-019: From q=8'hA5, en=1, mode=010, sin=1, one edge -> q=8'h4B, sout=0; then mode=101 with q loaded 8'h81 -> q=8'hC0.
- REQ-020: Load 8'h01; start, mode=110, steps=4 -> after edges 1..4 q = 02, 04, 08, 11 (hex); busy high from edge 0 through edge 3; done high only after edge 4.
- REQ-021: start with steps=0 -> q unchanged, busy never 1, done pulses one cycle after edge 0; en=1 during the start cycle has no effect.
- REQ-022: Start run steps=10, toggle en/mode/start while busy -> ignored; assert clear after step 3 -> q=8'hA5, busy=0, no done pulse.
- REQ-023: Issue start in the done cycle of a prior run -> new run accepted, busy=1 at that edge, no idle gap.
